// File: rtl/mesh_terminal_endpoint.sv
// mesh_terminal_endpoint
//   Real terminal for one port of the mesh. A host-side TX FIFO feeds the
//   mesh, and a three-state drain FSM pulls packets off the mesh output.
//   The FSM checks each packet's address and buffers accepted packets in an
//   RX FIFO for the host.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   tx_data/tx_push     host write into TX FIFO; tx_full flags a full FIFO
//   data_out_i_in       TX FIFO head toward mesh (first-word fall-through)
//   pndng_i_in          TX FIFO not empty
//   popin               mesh consumed the TX head
//   data_out/pndng      packet offered by the mesh / offer valid
//   pop                 one-cycle strobe consuming data_out
//   rx_data/rx_valid    RX FIFO head / not empty
//   rx_pop              host read strobe
//   rx_count            RX occupancy
//   misroute_cnt        saturating count of dropped misaddressed packets
//   err_sticky          [0] popin while TX empty, [1] tx_push while full
module mesh_terminal_endpoint #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 16,
  parameter logic [3:0]  ROW_ID     = 4'd0,
  parameter logic [3:0]  COL_ID     = 4'd0,
  parameter logic [7:0]  broadcast  = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [pckg_sz-1:0]            tx_data,
  input  logic                          tx_push,
  output logic                          tx_full,
  output logic [pckg_sz-1:0]            data_out_i_in,
  output logic                          pndng_i_in,
  input  logic                          popin,
  input  logic [pckg_sz-1:0]            data_out,
  input  logic                          pndng,
  output logic                          pop,
  output logic [pckg_sz-1:0]            rx_data,
  output logic                          rx_valid,
  input  logic                          rx_pop,
  output logic [$clog2(fifo_depth):0]   rx_count,
  output logic [15:0]                   misroute_cnt,
  output logic [1:0]                    err_sticky
);

  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(fifo_depth);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] tx_mem [fifo_depth];
  logic [AW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [1:0]         err_q, err_d;
  logic               tx_empty, tx_is_full, tx_do_pop, tx_do_push;

  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_is_full = (tx_cnt_q == DepthC);
  assign tx_do_pop  = popin && !tx_empty;
  // A push while full is still accepted when the head leaves in the same cycle.
  assign tx_do_push = tx_push && (!tx_is_full || tx_do_pop);

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_do_push) tx_wr_d = tx_wr_q + PtrOne;
    if (tx_do_pop)  tx_rd_d = tx_rd_q + PtrOne;
    if (tx_do_push && !tx_do_pop)      tx_cnt_d = tx_cnt_q + CntOne;
    else if (!tx_do_push && tx_do_pop) tx_cnt_d = tx_cnt_q - CntOne;
    err_d = err_q | {tx_push && tx_is_full && !popin, popin && tx_empty};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      err_q    <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wr_q] <= tx_data;
  end

  assign tx_full       = tx_is_full;
  assign pndng_i_in    = !tx_empty;
  // Gate the head so the output reads zero whenever the FIFO is empty.
  assign data_out_i_in = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign err_sticky    = err_q;

  // ---------------------------------------------------------------------------
  // RX drain FSM and address check
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StPop, StSettle} state_e;

  state_e             state_q, state_d;
  logic [pckg_sz-1:0] rx_mem [fifo_depth];
  logic [AW-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [15:0]        mis_q, mis_d;
  logic               rx_empty, accept, rx_wr, rx_do_pop;

  assign accept = (data_out[pckg_sz-1 -: 8] == broadcast) ||
                  ((data_out[pckg_sz-9 -: 4] == ROW_ID) &&
                   (data_out[pckg_sz-13 -: 4] == COL_ID));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle:   if (pndng && (rx_cnt_q != DepthC)) state_d = StPop;
      StPop: begin
        pop     = 1'b1;
        state_d = StSettle;
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign rx_empty  = (rx_cnt_q == '0);
  // Room was guaranteed on entry to StPop, and only the host can drain meanwhile.
  assign rx_wr     = (state_q == StPop) && accept;
  assign rx_do_pop = rx_pop && !rx_empty;

  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    mis_d    = mis_q;
    if (rx_wr)     rx_wr_d = rx_wr_q + PtrOne;
    if (rx_do_pop) rx_rd_d = rx_rd_q + PtrOne;
    if (rx_wr && !rx_do_pop)      rx_cnt_d = rx_cnt_q + CntOne;
    else if (!rx_wr && rx_do_pop) rx_cnt_d = rx_cnt_q - CntOne;
    if ((state_q == StPop) && !accept && (mis_q != 16'hFFFF)) mis_d = mis_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      mis_q    <= '0;
    end else begin
      state_q  <= state_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      mis_q    <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wr_q] <= data_out;
  end

  assign rx_valid     = !rx_empty;
  assign rx_data      = rx_empty ? '0 : rx_mem[rx_rd_q];
  assign rx_count     = rx_cnt_q;
  assign misroute_cnt = mis_q;

endmodule

// File: doc/mesh_terminal_endpoint.md
Name: mesh_terminal_endpoint

Overview:
- Synthesizable terminal that attaches to one port of mesh_gnrtr. It is the far-end counterpart of the per-terminal signals the mesh exposes.
- Transmit path: a host-side TX FIFO presents packets to the mesh on data_out_i_in/pndng_i_in and retires them on popin.
- Receive path: drains the mesh output (pndng/data_out) with pop, checks the destination address against this terminal's coordinates, and buffers accepted packets in an RX FIFO for the host.
- Replaces the behavioural driver/monitor pair wherever real terminals are instantiated around the mesh.

Parameters:
- pckg_sz, 40, packet width in bits.
- fifo_depth, 16, depth of each of the TX and RX FIFOs (power of 2, minimum 2).
- ROW_ID, 0, this terminal's row coordinate (4 bits).
- COL_ID, 0, this terminal's column coordinate (4 bits).
- broadcast, 8'hFF, value of the next-jump field that marks a broadcast packet.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low reset.
- tx_data, in, pckg_sz, host packet to send.
- tx_push, in, 1, host write strobe.
- tx_full, out, 1, TX FIFO full.
- data_out_i_in, out, pckg_sz, head of TX FIFO, driven to mesh.
- pndng_i_in, out, 1, TX FIFO not empty.
- popin, in, 1, mesh consumed the head packet.
- data_out, in, pckg_sz, packet offered by mesh.
- pndng, in, 1, mesh has a packet for this terminal.
- pop, out, 1, one-cycle strobe consuming data_out.
- rx_data, out, pckg_sz, head of RX FIFO.
- rx_valid, out, 1, RX FIFO not empty.
- rx_pop, in, 1, host read strobe.
- rx_count, out, $clog2(fifo_depth)+1, RX occupancy.
- misroute_cnt, out, 16, saturating count of dropped misaddressed packets.
- err_sticky, out, 2, bit0 = popin while TX empty; bit1 = tx_push while full. Sticky until reset.

Behaviour:
- Packet fields:
  - next-jump [pckg_sz-1 -: 8]
  - dest row [pckg_sz-9 -: 4]
  - dest col [pckg_sz-13 -: 4]
  - mode [pckg_sz-17]
  - payload below that
- Reset (reset=0, asynchronous): both FIFOs are empty, and all outputs are 0: tx_full, pndng_i_in, pop, rx_valid, rx_count, misroute_cnt, err_sticky, data_out_i_in, rx_data. Reset mid-transfer discards FIFO contents. Any pop in flight is dropped.
- TX FIFO:
  - tx_push with !tx_full writes at the clock edge. pndng_i_in rises the next cycle.
  - data_out_i_in always shows the head. It is first-word-fall-through with zero added latency.
  - popin with pndng_i_in=1 advances the head at the edge.
  - Simultaneous push and popin while full: the pop is honoured and the push is accepted (occupancy unchanged).
  - popin while empty is ignored and sets err_sticky[0].
  - tx_push while full (and no popin) is dropped and sets err_sticky[1].
  - Pointers wrap modulo fifo_depth.
- RX FSM, states IDLE, POP, SETTLE:
  - IDLE → POP when pndng=1 and the RX FIFO has at least one free slot.
  - POP: pop=1 for exactly one cycle. data_out is sampled in this same cycle.
  - POP → SETTLE unconditionally. pop=0 in SETTLE, giving the mesh one cycle to update pndng.
  - SETTLE → IDLE.
  - Maximum drain rate is one packet per 3 cycles. pop is never asserted on consecutive cycles.
- Address check, applied to the packet sampled in POP:
  - Accept if next-jump == broadcast, or if dest row == ROW_ID and dest col == COL_ID.
  - Accepted packets are written to the RX FIFO at the POP edge. rx_valid is high the following cycle.
  - Rejected packets are dropped. misroute_cnt increments at the same edge and saturates at 16'hFFFF.
- RX FIFO:
  - rx_pop with rx_valid advances the head. rx_pop while empty is ignored.
  - An RX write and rx_pop in the same cycle keeps rx_count unchanged.
  - The FSM never leaves IDLE when rx_count == fifo_depth. Backpressure holds off the mesh; no packet is lost.
- pndng dropping while in POP or SETTLE has no effect; the sampled packet is already committed.

Test Plan:
- Reset: hold reset=0 with pndng=1 and tx_push=1 → pop, pndng_i_in, rx_valid, misroute_cnt all stay 0; after release (ROW_ID=2, COL_ID=3) the first pop appears 1 cycle after the first edge.
- TX flow: push 3 packets 40'hA1..., 40'hA2..., 40'hA3...; pulse popin three times → data_out_i_in presents them in order; pndng_i_in falls after the third popin; a 4th popin sets err_sticky[0]=1.
- RX accept and drop:
  - Mesh offers dest row 2/col 3 → one pop pulse, and rx_data equals the packet with rx_count=1.
  - Next it offers dest row 1/col 3 → pop pulse, no RX write, misroute_cnt=1.
  - Then next-jump 8'hFF with other coordinates → accepted, rx_count=2.
- Backpressure: fill the RX FIFO with 16 accepted packets while the host never pops → pop stays 0 with pndng=1 and rx_count=16; one rx_pop → exactly one more pop within 2 cycles.
- Full TX boundary: push 17 times without popin → tx_full=1 after the 16th push, the 17th is dropped, err_sticky[1]=1; simultaneous push and popin while full → tx_full stays 1 and order is preserved.
- Async reset mid-operation: assert reset low between clock edges while in SETTLE with rx_count=5 → all outputs are 0 immediately, before the next edge, and the FSM restarts in IDLE.
